// File: rtl/serial_pkg.sv
// serial_pkg: shared definitions for the serial word source.
//   state_t : two-state serializer encoding (ST_IDLE / ST_SHIFT)
//   clog2   : ceiling log2, used to size the bit-index counter
package serial_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Ceiling log2; returns 0 for n <= 1.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        longint unsigned v;
        r = 0;
        v = 1;
        while (v < longint'(n)) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_word_src.sv
// serial_word_src: parallel-to-serial source, LSB first, one bit per clock.
// Accepts a WIDTH-bit word over valid/ready and streams it gaplessly; a new
// word can be taken on the last bit of the current one.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   in_data/in_valid   : word offered by the source
//   in_ready           : combinational; high when idle or on the last bit
//   out/out_valid      : serial bit and its qualifier
//   out_last           : current bit is bit WIDTH-1 of the word
//   out_parity         : XOR of the whole current word (use with out_last)
module serial_word_src
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out,
    output logic             out_valid,
    output logic             out_last,
    output logic             out_parity
);

    localparam int unsigned       CNT_W    = clog2(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   sreg, sreg_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               par, par_nxt;

    logic               at_last;
    logic               accept;

    // Handshake: ready depends only on state, cnt and rst.
    assign at_last  = (cnt == CNT_LAST);
    assign in_ready = !rst && ((state == ST_IDLE) || ((state == ST_SHIFT) && at_last));
    assign accept   = in_valid && in_ready;

    // Outputs decoded purely from registered state.
    assign out_valid  = (state == ST_SHIFT);
    assign out        = out_valid && sreg[0];
    assign out_last   = out_valid && at_last;
    assign out_parity = par;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            sreg  <= '0;
            cnt   <= '0;
            par   <= 1'b0;
        end else begin
            state <= state_nxt;
            sreg  <= sreg_nxt;
            cnt   <= cnt_nxt;
            par   <= par_nxt;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_nxt = state;
        sreg_nxt  = sreg;
        cnt_nxt   = cnt;
        par_nxt   = par;

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    sreg_nxt  = in_data;
                    cnt_nxt   = '0;
                    par_nxt   = ^in_data;
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (at_last) begin
                    // Last bit: reload for a gapless stream or fall back to idle.
                    if (accept) begin
                        sreg_nxt = in_data;
                        cnt_nxt  = '0;
                        par_nxt  = ^in_data;
                    end else begin
                        sreg_nxt  = sreg >> 1;
                        cnt_nxt   = '0;
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    sreg_nxt = sreg >> 1;
                    cnt_nxt  = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

`ifdef FORMAL
    // Bit index stays within the word.
    a_cnt_range: assert property (@(posedge clk) disable iff (rst)
        cnt <= CNT_LAST);

    // A word taken on the last bit keeps the stream alive without a bubble.
    a_gapless: assert property (@(posedge clk) disable iff (rst)
        (out_last && accept) |=> out_valid);
`endif

endmodule
